// File: rtl/sigpulse_pkg.sv
// Shared definitions for the multi-channel pulse generator: channel state encoding and default widths.
// Burst mode (GAP state, repeat counter) is compiled in by SIGPULSE_MC_BURST_EN.
package sigpulse_pkg;

  localparam int CH_NUM_DEF    = 4;
  localparam int RAM_WIDTH_DEF = 32;
  localparam int REP_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/sigpulse_ch.sv
// One pulse-generator channel: trigger delay, pulse width and, with SIGPULSE_MC_BURST_EN defined,
// gap/repeat bursts. Config is latched when a trigger is accepted; pulse output comes from a register.
module sigpulse_ch
  import sigpulse_pkg::*;
#(
  parameter int CW = RAM_WIDTH_DEF,
  parameter int RW = REP_WIDTH_DEF
) (
  input  logic          io_clk,
  input  logic          io_rst_n,
  input  logic          en,
  input  logic          dis,
  input  logic          default_level,
  input  logic [CW-1:0] trig_delay,
  input  logic [CW-1:0] pulse_width,
  input  logic [CW-1:0] pulse_gap,
  input  logic [RW-1:0] rep_num,
  output logic          pulse_out,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] width_reg;
  logic          pulse_reg;
  logic          done_reg;

`ifdef SIGPULSE_MC_BURST_EN
  localparam logic [RW-1:0] REP_ONE = RW'(1);
  logic [CW-1:0] gap_reg;
  logic [RW-1:0] rem_reg;
`else
  logic unused_burst_cfg;
  assign unused_burst_cfg = ^{pulse_gap, rep_num};
`endif

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      width_reg <= '0;
      pulse_reg <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SIGPULSE_MC_BURST_EN
      gap_reg   <= '0;
      rem_reg   <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (dis) begin
        // Abort: the strobe is only meaningful if a sequence was actually running.
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        pulse_reg <= 1'b0;
        done_reg  <= (state_reg != ST_IDLE);
      end else if (en && (pulse_width != '0)) begin
        width_reg <= pulse_width;
`ifdef SIGPULSE_MC_BURST_EN
        gap_reg   <= (pulse_gap == '0) ? CNT_ONE : pulse_gap;
        rem_reg   <= (rep_num == '0) ? '0 : rep_num - REP_ONE;
`endif
        if (trig_delay != '0) begin
          state_reg <= ST_DELAY;
          cnt_reg   <= trig_delay - CNT_ONE;
          pulse_reg <= 1'b0;
        end else begin
          state_reg <= ST_ACTIVE;
          cnt_reg   <= pulse_width - CNT_ONE;
          pulse_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          ST_DELAY: begin
            if (cnt_reg == '0) begin
              state_reg <= ST_ACTIVE;
              cnt_reg   <= width_reg - CNT_ONE;
              pulse_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - CNT_ONE;
`ifdef SIGPULSE_MC_BURST_EN
            end else if (rem_reg != '0) begin
              state_reg <= ST_GAP;
              cnt_reg   <= gap_reg - CNT_ONE;
              rem_reg   <= rem_reg - REP_ONE;
              pulse_reg <= 1'b0;
`endif
            end else begin
              state_reg <= ST_IDLE;
              pulse_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
`ifdef SIGPULSE_MC_BURST_EN
          ST_GAP: begin
            if (cnt_reg == '0) begin
              state_reg <= ST_ACTIVE;
              cnt_reg   <= width_reg - CNT_ONE;
              pulse_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Disable overrides the registered pulse immediately, ahead of the state change.
  assign pulse_out = (pulse_reg & ~dis) ^ default_level;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

endmodule

// File: rtl/sigpulse_mc.sv
// Multi-channel pulse generator: CH_NUM independent sigpulse_ch instances sliced from packed config buses.
// Burst mode per channel is enabled with SIGPULSE_MC_BURST_EN.
module sigpulse_mc
  import sigpulse_pkg::*;
#(
  parameter int CH_NUM     = CH_NUM_DEF,
  parameter int _RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int REP_WIDTH  = REP_WIDTH_DEF
) (
  input  logic                         io_clk,
  input  logic                         io_rst_n,
  input  logic [CH_NUM-1:0]            io_en,
  input  logic [CH_NUM-1:0]            pwm_dis,
  input  logic [CH_NUM-1:0]            io_defaultLevel,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_trigDelay,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_pulseWidth,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_pulseGap,
  input  logic [CH_NUM*REP_WIDTH-1:0]  io_repeat,
  output logic [CH_NUM-1:0]            io_pulseOut,
  output logic [CH_NUM-1:0]            pulse_busy,
  output logic [CH_NUM-1:0]            pulse_valid
);

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      sigpulse_ch #(
        .CW(_RAM_WIDTH),
        .RW(REP_WIDTH)
      ) u_ch (
        .io_clk       (io_clk),
        .io_rst_n     (io_rst_n),
        .en           (io_en[gi]),
        .dis          (pwm_dis[gi]),
        .default_level(io_defaultLevel[gi]),
        .trig_delay   (io_trigDelay[gi*_RAM_WIDTH +: _RAM_WIDTH]),
        .pulse_width  (io_pulseWidth[gi*_RAM_WIDTH +: _RAM_WIDTH]),
        .pulse_gap    (io_pulseGap[gi*_RAM_WIDTH +: _RAM_WIDTH]),
        .rep_num      (io_repeat[gi*REP_WIDTH +: REP_WIDTH]),
        .pulse_out    (io_pulseOut[gi]),
        .busy         (pulse_busy[gi]),
        .done         (pulse_valid[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sigpulse_mc.sv
// Directed bench for sigpulse_mc: table of single-trigger scenarios plus abort, retrigger and reset sequences.
// Expectations follow SIGPULSE_MC_BURST_EN when it is defined.
module tb_sigpulse_mc;

  localparam int CH  = 4;
  localparam int CW  = 32;
  localparam int RPW = 16;
  localparam logic [CH-1:0] DL = 4'b1010;

  logic              io_clk = 1'b0;
  logic              io_rst_n;
  logic [CH-1:0]     io_en;
  logic [CH-1:0]     pwm_dis;
  logic [CH-1:0]     io_defaultLevel;
  logic [CH*CW-1:0]  io_trigDelay;
  logic [CH*CW-1:0]  io_pulseWidth;
  logic [CH*CW-1:0]  io_pulseGap;
  logic [CH*RPW-1:0] io_repeat;
  logic [CH-1:0]     io_pulseOut;
  logic [CH-1:0]     pulse_busy;
  logic [CH-1:0]     pulse_valid;

  int n_checks = 0;
  int n_fail   = 0;

  sigpulse_mc #(
    .CH_NUM(CH),
    ._RAM_WIDTH(CW),
    .REP_WIDTH(RPW)
  ) dut (
    .io_clk         (io_clk),
    .io_rst_n       (io_rst_n),
    .io_en          (io_en),
    .pwm_dis        (pwm_dis),
    .io_defaultLevel(io_defaultLevel),
    .io_trigDelay   (io_trigDelay),
    .io_pulseWidth  (io_pulseWidth),
    .io_pulseGap    (io_pulseGap),
    .io_repeat      (io_repeat),
    .io_pulseOut    (io_pulseOut),
    .pulse_busy     (pulse_busy),
    .pulse_valid    (pulse_valid)
  );

  always #5 io_clk = ~io_clk;

  // Expected waveforms as bit masks: bit k = value in the k-th cycle after the trigger cycle.
  typedef struct {
    int          ch;
    logic [31:0] d;
    logic [31:0] w;
    logic [31:0] g;
    logic [15:0] c;
    logic [31:0] act;
    logic [31:0] busy;
    logic [31:0] vld;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_cycle(input int tag, input int k, input int ch,
                             input logic [31:0] act, input logic [31:0] busy, input logic [31:0] vld);
    logic [CH-1:0] e_out, e_busy, e_vld;
    e_out  = DL;
    e_busy = '0;
    e_vld  = '0;
    e_out[ch]  = DL[ch] ^ act[k];
    e_busy[ch] = busy[k];
    e_vld[ch]  = vld[k];
    chk($sformatf("t%0d.k%0d out", tag, k), io_pulseOut, e_out);
    chk($sformatf("t%0d.k%0d busy", tag, k), pulse_busy, e_busy);
    chk($sformatf("t%0d.k%0d valid", tag, k), pulse_valid, e_vld);
  endtask

  // Pulses io_en on one channel for one cycle; returns at the negedge of the first cycle after it.
  task automatic trigger(input int ch, input logic [31:0] d, input logic [31:0] w,
                         input logic [31:0] g, input logic [15:0] c);
    @(negedge io_clk);
    io_trigDelay[ch*CW +: CW]  = d;
    io_pulseWidth[ch*CW +: CW] = w;
    io_pulseGap[ch*CW +: CW]   = g;
    io_repeat[ch*RPW +: RPW]   = c;
    io_en     = '0;
    io_en[ch] = 1'b1;
    @(negedge io_clk);
    io_en         = '0;
    io_trigDelay  = {$urandom(), $urandom(), $urandom(), $urandom()};
    io_pulseWidth = {$urandom(), $urandom(), $urandom(), $urandom()};
    io_pulseGap   = {$urandom(), $urandom(), $urandom(), $urandom()};
    io_repeat     = {$urandom(), $urandom()};
  endtask

  initial begin
    vecs[0] = '{0, 32'd0,  32'd5, 32'd0, 16'd1, 32'h3E, 32'h3E, 32'h40};
    vecs[2] = '{0, 32'd2,  32'd0, 32'd3, 16'd2, 32'h0,  32'h0,  32'h0};
    vecs[3] = '{2, 32'd1,  32'd3, 32'd5, 16'd0, 32'h1C, 32'h1E, 32'h20};
    vecs[5] = '{1, 32'd20, 32'd1, 32'd1, 16'd1, 32'h200000, 32'h3FFFFE, 32'h400000};
`ifdef SIGPULSE_MC_BURST_EN
    vecs[1] = '{1, 32'd3,  32'd2, 32'd4, 16'd3, 32'h30C30, 32'h3FFFE, 32'h40000};
    vecs[4] = '{3, 32'd0,  32'd2, 32'd0, 16'd2, 32'h36, 32'h3E, 32'h40};
    vecs[6] = '{2, 32'd0,  32'd1, 32'd3, 16'd2, 32'h22, 32'h3E, 32'h40};
`else
    vecs[1] = '{1, 32'd3,  32'd2, 32'd4, 16'd3, 32'h30, 32'h3E, 32'h40};
    vecs[4] = '{3, 32'd0,  32'd2, 32'd0, 16'd2, 32'h06, 32'h06, 32'h08};
    vecs[6] = '{2, 32'd0,  32'd1, 32'd3, 16'd2, 32'h02, 32'h02, 32'h04};
`endif

    io_rst_n        = 1'b0;
    io_en           = '0;
    pwm_dis         = '0;
    io_defaultLevel = DL;
    io_trigDelay    = '0;
    io_pulseWidth   = '0;
    io_pulseGap     = '0;
    io_repeat       = '0;
    #1;
    chk("reset out", io_pulseOut, DL);
    chk("reset busy", pulse_busy, '0);
    chk("reset valid", pulse_valid, '0);
    repeat (3) @(negedge io_clk);
    io_rst_n = 1'b1;
    @(negedge io_clk);
    chk("post-reset busy", pulse_busy, '0);

    // Table-driven single-trigger scenarios
    for (int r = 0; r < NV; r++) begin
      trigger(vecs[r].ch, vecs[r].d, vecs[r].w, vecs[r].g, vecs[r].c);
      for (int k = 1; k <= 30; k++) begin
        check_cycle(r, k, vecs[r].ch, vecs[r].act, vecs[r].busy, vecs[r].vld);
        @(negedge io_clk);
      end
    end

    // Abort of ch2 in its 3rd active cycle
    trigger(2, 32'd0, 32'd100, 32'd1, 16'd1);
    for (int k = 1; k <= 2; k++) begin
      check_cycle(20, k, 2, 32'h6, 32'h6, 32'h0);
      @(negedge io_clk);
    end
    pwm_dis[2] = 1'b1;
    #1;
    chk("abort same-cycle out", io_pulseOut, DL);
    chk("abort same-cycle busy", pulse_busy, 4'b0100);
    @(negedge io_clk);
    pwm_dis = '0;
    chk("abort valid", pulse_valid, 4'b0100);
    chk("abort busy", pulse_busy, '0);
    chk("abort out", io_pulseOut, DL);
    @(negedge io_clk);
    chk("abort valid clears", pulse_valid, '0);
    // io_en together with pwm_dis, and io_en while pwm_dis is held
    io_pulseWidth[2*CW +: CW] = 32'd5;
    io_trigDelay[2*CW +: CW]  = 32'd0;
    io_en[2]   = 1'b1;
    pwm_dis[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge io_clk);
      chk($sformatf("dis+en busy %0d", k), pulse_busy, '0);
      chk($sformatf("dis+en valid %0d", k), pulse_valid, '0);
      chk($sformatf("dis+en out %0d", k), io_pulseOut, DL);
    end
    io_en   = '0;
    pwm_dis = '0;
    @(negedge io_clk);
    chk("dis release busy", pulse_busy, '0);
    chk("dis release valid", pulse_valid, '0);

    // Retrigger of ch3 in its 5th active cycle with a shorter width
    trigger(3, 32'd0, 32'd10, 32'd1, 16'd1);
    for (int k = 1; k <= 14; k++) begin
      check_cycle(30, k, 3, 32'h3FE, 32'h3FE, 32'h400);
      if (k == 5) begin
        io_trigDelay[3*CW +: CW]  = 32'd0;
        io_pulseWidth[3*CW +: CW] = 32'd4;
        io_repeat[3*RPW +: RPW]   = 16'd1;
        io_en[3] = 1'b1;
      end
      @(negedge io_clk);
      io_en = '0;
    end

    // Reset while every channel sits in DELAY
    for (int ch = 0; ch < CH; ch++) begin
      io_trigDelay[ch*CW +: CW]  = 32'($urandom_range(30, 8));
      io_pulseWidth[ch*CW +: CW] = 32'($urandom_range(8, 1));
      io_pulseGap[ch*CW +: CW]   = 32'($urandom_range(5, 0));
      io_repeat[ch*RPW +: RPW]   = 16'($urandom_range(4, 0));
    end
    io_en = '1;
    @(negedge io_clk);
    io_en = '0;
    repeat (2) @(negedge io_clk);
    chk("pre-reset all busy", pulse_busy, '1);
    io_rst_n = 1'b0;
    #1;
    chk("async reset out", io_pulseOut, DL);
    chk("async reset busy", pulse_busy, '0);
    chk("async reset valid", pulse_valid, '0);
    repeat (2) @(negedge io_clk);
    io_rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge io_clk);
      chk($sformatf("after reset busy %0d", k), pulse_busy, '0);
      chk($sformatf("after reset valid %0d", k), pulse_valid, '0);
      chk($sformatf("after reset out %0d", k), io_pulseOut, DL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sigpulse_mc.md
Name: sigpulse_mc

Overview:
- Multi-channel successor to the single-channel pulse generator.
- CH_NUM independent channels; each has a programmable trigger delay, pulse width, inter-pulse gap, repeat count and idle-level polarity.
- Sits between the register/RAM configuration block and the trigger output pins.
- Per channel it reports busy and a one-cycle done strobe, replacing the old pulse_valid.

Parameters:
- CH_NUM, 4, number of independent channels (1..16).
- _RAM_WIDTH, 32, width of the delay/width/gap counters in clock cycles.
- REP_WIDTH, 16, width of the repeat-count field.

Ports:
- io_clk  input  1  single system clock.
- io_rst_n  input  1  asynchronous active-low reset.
- io_en  input  CH_NUM  per-channel trigger strobe; samples that channel's config.
- pwm_dis  input  CH_NUM  per-channel abort/disable.
- io_defaultLevel  input  CH_NUM  idle output level per channel.
- io_trigDelay  input  CH_NUM*_RAM_WIDTH  delay in cycles; channel i uses bits [i*_RAM_WIDTH +: _RAM_WIDTH].
- io_pulseWidth  input  CH_NUM*_RAM_WIDTH  active width in cycles.
- io_pulseGap  input  CH_NUM*_RAM_WIDTH  idle cycles between burst pulses.
- io_repeat  input  CH_NUM*REP_WIDTH  pulses per burst.
- io_pulseOut  output  CH_NUM  pulse outputs.
- pulse_busy  output  CH_NUM  channel not IDLE.
- pulse_valid  output  CH_NUM  one-cycle done/abort strobe.

Behaviour:
- Reset (io_rst_n=0, asynchronous): all channels go to IDLE and counters clear. pulse_busy=0, pulse_valid=0, io_pulseOut=io_defaultLevel.
- Per-channel FSM states: IDLE, DELAY, ACTIVE, GAP.
- Config is latched on the io_en cycle. Later input changes do not affect a running sequence.
- Trigger at cycle T with delay D, width W, gap G, repeat C:
  - D>0: DELAY for D cycles, then ACTIVE from T+1+D.
  - D=0: ACTIVE from T+1.
- ACTIVE lasts exactly W cycles. Then, if pulses remain, GAP for G cycles followed by ACTIVE again; otherwise IDLE.
- G=0 is treated as 1. C=0 is treated as 1.
- W=0: the trigger is ignored. The channel stays in its current state and no strobe is issued.
- io_pulseOut[i] = (state==ACTIVE) XOR io_defaultLevel[i], driven from a register with no combinational path from io_en.
- pulse_busy[i] = 1 in any non-IDLE state.
- pulse_valid[i] pulses for one cycle, registered, in the first IDLE cycle after the last ACTIVE cycle.
- Retrigger while busy (io_en=1 and not IDLE): the channel reloads config and restarts at DELAY/ACTIVE as for a fresh trigger. No pulse_valid is issued for the abandoned sequence.
- pwm_dis[i]=1:
  - Highest priority, above io_en in the same cycle.
  - io_pulseOut is forced to io_defaultLevel combinationally in that same cycle.
  - State goes to IDLE on the next edge.
  - pulse_valid pulses the next cycle only if the channel was busy.
  - While held, the channel stays IDLE and ignores io_en.
- Channels are fully independent. Simultaneous triggers on different channels do not interact.
- Counters are down-counters of _RAM_WIDTH bits. A value of 2^_RAM_WIDTH-1 must count fully, with no wrap.

Optional Feature:
- Macro SIGPULSE_MC_BURST_EN.
- Defined: GAP state, io_pulseGap and io_repeat are functional as described above.
- Undefined: GAP state and repeat counter are removed. Each trigger produces exactly one pulse and io_pulseGap/io_repeat are ignored. The ports remain present so the interface is unchanged.

Decomposition:
- Shared package sigpulse_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DELAY=2'd1, ST_ACTIVE=2'd2, ST_GAP=2'd3;
  - default widths.
- Sub-module sigpulse_ch implements one channel: FSM, counters and output register.
- sigpulse_mc is a generate loop of CH_NUM sigpulse_ch instances plus bus slicing.

Test Plan:
- Ch0, D=0, W=5, C=1, defaultLevel=0, trigger at cycle 10 -> io_pulseOut[0]=1 in cycles 11..15; pulse_valid[0]=1 at cycle 16 only; busy in 11..15.
- Ch1, D=3, W=2, G=4, C=3, defaultLevel=1 -> output low in cycles 14..15, 20..21, 26..27 (trigger at 10); single pulse_valid at 28. With SIGPULSE_MC_BURST_EN undefined -> only 14..15 and valid at 16.
- Ch2, W=100, pwm_dis asserted at 3rd ACTIVE cycle -> output returns to idle level in the same cycle; pulse_valid one cycle later; io_en together with pwm_dis -> ignored.
- Ch3 retrigger: W=10, new io_en with W=4 at 5th ACTIVE cycle -> pulse extends 4 more cycles from the next edge; only one pulse_valid.
- W=0 trigger and C=0, G=0 configs -> W=0 gives no busy and no valid; C=0 yields one pulse; G=0 yields a 1-cycle gap.
- Reset asserted mid-DELAY on all channels with random configs -> all outputs immediately at defaultLevel, busy=0; no valid strobe after reset release.
